// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - Avalon-MM SRAM block-read master feeding an in-order valid/ready stream.
// Optional feature macro: SRAM_RD_STRIDE_EN (adds cmd_stride; default stride is 1).
`timescale 1ns/1ps
module sram_stream_reader #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_start,
    input  logic [ADDR_W-1:0]   cmd_base,
    input  logic [ADDR_W:0]     cmd_len,
`ifdef SRAM_RD_STRIDE_EN
    input  logic [ADDR_W-1:0]   cmd_stride,
`endif
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   sram_address,
    output logic                sram_chipselect,
    output logic                sram_write,
    output logic [DATA_W/8-1:0] sram_byteenable,
    output logic                sram_clken,
    input  logic [DATA_W-1:0]   sram_readdata,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready,
    output logic                st_last
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_addr;
    logic [ADDR_W:0]         r_issue_left;
    logic [ADDR_W:0]         r_pop_left;
    logic [READ_LATENCY-1:0] r_tag;
    logic [DATA_W-1:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;

    logic [ADDR_W-1:0]       w_stride;
    logic [CNT_W-1:0]        w_in_flight;
    logic [CNT_W:0]          w_occupied;
    logic [READ_LATENCY-1:0] w_tag_next;
    logic                    w_issue;
    logic                    w_push;
    logic                    w_pop;

`ifdef SRAM_RD_STRIDE_EN
    logic [ADDR_W-1:0]       r_stride;
    assign w_stride = r_stride;
`else
    assign w_stride = ADDR_W'(1);
`endif

    // Every word either in flight or buffered holds a FIFO slot, so issue only while one is free.
    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_in_flight = w_in_flight + CNT_W'(r_tag[i]);
        end
        w_occupied = {1'b0, r_count} + {1'b0, w_in_flight};
        w_tag_next = r_tag << 1;
        w_tag_next[0] = w_issue;
    end

    assign w_issue = (r_state == S_ISSUE) && (w_occupied < (CNT_W+1)'(FIFO_DEPTH));
    assign w_push  = r_tag[READ_LATENCY-1];
    assign w_pop   = st_valid && st_ready;

    assign busy            = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign done            = (r_state == S_DONE);
    assign sram_address    = r_addr;
    assign sram_chipselect = w_issue;
    assign sram_write      = 1'b0;
    assign sram_byteenable = '1;
    assign sram_clken      = 1'b1;
    assign st_valid        = (r_count != '0);
    assign st_data         = st_valid ? r_mem[r_rd_ptr] : '0;
    assign st_last         = st_valid && (r_pop_left == (ADDR_W+1)'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_issue_left <= '0;
            r_pop_left   <= '0;
`ifdef SRAM_RD_STRIDE_EN
            r_stride     <= '0;
`endif
        end else begin
            if (w_pop) begin
                r_pop_left <= r_pop_left - (ADDR_W+1)'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (cmd_start) begin
                        if (cmd_len == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_addr       <= cmd_base;
                            r_issue_left <= cmd_len;
                            r_pop_left   <= cmd_len;
`ifdef SRAM_RD_STRIDE_EN
                            r_stride     <= cmd_stride;
`endif
                            r_state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_addr       <= r_addr + w_stride;
                        r_issue_left <= r_issue_left - (ADDR_W+1)'(1);
                        if (r_issue_left == (ADDR_W+1)'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && st_last) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The tag exiting the shift register marks the cycle sram_readdata is valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_tag <= w_tag_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sram_readdata;
        end
    end
endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - randomized self-checking bench for sram_stream_reader against a queue-based reference.
`timescale 1ns/1ps
module tb_sram_stream_reader;
    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_start;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
`ifdef SRAM_RD_STRIDE_EN
    logic [AW-1:0] cmd_stride;
`endif
    logic          busy, done, sram_chipselect, sram_write, sram_clken;
    logic [AW-1:0] sram_address;
    logic [DW/8-1:0] sram_byteenable;
    logic [DW-1:0] sram_readdata, st_data;
    logic          st_valid, st_ready, st_last;

    always #5 clk = ~clk;

    sram_stream_reader dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_base(cmd_base), .cmd_len(cmd_len),
`ifdef SRAM_RD_STRIDE_EN
        .cmd_stride(cmd_stride),
`endif
        .busy(busy), .done(done), .sram_address(sram_address), .sram_chipselect(sram_chipselect),
        .sram_write(sram_write), .sram_byteenable(sram_byteenable), .sram_clken(sram_clken),
        .sram_readdata(sram_readdata), .st_data(st_data), .st_valid(st_valid),
        .st_ready(st_ready), .st_last(st_last)
    );

    // SRAM: address registered, output unregistered -> one cycle read latency.
    logic [DW-1:0] mem [4096];
    logic [DW-1:0] sram_q;
    always @(posedge clk) if (sram_chipselect) sram_q <= mem[sram_address];
    assign sram_readdata = sram_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] got_q [$];
    bit            last_q [$];
    int            pop_cyc_q [$];
    logic [AW-1:0] addr_q [$];
    int            done_cyc_q [$];
    int            busy_cyc_q [$];
    int            credit_err = 0, stab_err = 0, n_issued = 0, n_popped = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            n_issued   <= 0;
            n_popped   <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (sram_chipselect) begin
                addr_q.push_back(sram_address);
                if (n_issued - n_popped >= DEPTH) credit_err <= credit_err + 1;
                n_issued <= n_issued + 1;
            end
            if (prev_stall && (!st_valid || st_data !== prev_data)) stab_err <= stab_err + 1;
            if (st_valid && st_ready) begin
                got_q.push_back(st_data);
                last_q.push_back(st_last);
                pop_cyc_q.push_back(cyc);
                n_popped <= n_popped + 1;
            end
            if (done) done_cyc_q.push_back(cyc);
            if (busy) busy_cyc_q.push_back(cyc);
            prev_stall <= st_valid && !st_ready;
            prev_data  <= st_data;
        end
    end

    int n_cmp = 0, n_bad = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int t0, g0, a0, d0, b0, ce0, se0;
    int model_stride = 1;

    task automatic snap();
        g0 = got_q.size(); a0 = addr_q.size(); d0 = done_cyc_q.size();
        b0 = busy_cyc_q.size(); ce0 = credit_err; se0 = stab_err;
    endtask

    function automatic logic ready_val(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (k >= 6 && k < 26) return 1'b0;
        return ($urandom_range(2) != 0);
    endfunction

    task automatic verify(input logic [AW-1:0] base, input int len);
        int n_err = 0, l_err = 0, a_err = 0;
        logic [AW-1:0] ea;
        check("word_count", got_q.size() - g0, len);
        check("addr_count", addr_q.size() - a0, len);
        for (int i = 0; i < len; i++) begin
            ea = base + AW'(i * model_stride);
            if (g0 + i < got_q.size()) begin
                if (got_q[g0+i] !== mem[ea]) n_err++;
                if (last_q[g0+i] != (i == len - 1)) l_err++;
            end
            if (a0 + i < addr_q.size() && addr_q[a0+i] !== ea) a_err++;
        end
        check("data", n_err, 0);
        check("last_flag", l_err, 0);
        check("address", a_err, 0);
        check("done_pulses", done_cyc_q.size() - d0, 1);
        check("credit", credit_err - ce0, 0);
        check("stall_stable", stab_err - se0, 0);
        if (done_cyc_q.size() > d0) begin
            if (len == 0) begin
                check("zero_done_cycle", done_cyc_q[d0] - t0, 1);
                check("zero_busy", busy_cyc_q.size() - b0, 0);
            end else if (got_q.size() - g0 == len) begin
                check("done_after_last", done_cyc_q[d0] - pop_cyc_q[g0+len-1], 1);
            end
        end
    endtask

    task automatic start_cmd(input logic [AW-1:0] base, input int len, input int mode);
        @(posedge clk); #1;
        cmd_start = 1'b1; cmd_base = base; cmd_len = (AW+1)'(len);
`ifdef SRAM_RD_STRIDE_EN
        cmd_stride = AW'(model_stride);
`endif
        st_ready = ready_val(mode, 0);
        t0 = cyc;
    endtask

    task automatic run_cmd(input logic [AW-1:0] base, input int len, input int mode, input int ign_at);
        int k = 0;
        bit fin = 1'b0;
        snap();
        start_cmd(base, len, mode);
        while (!fin && k < 20000) begin
            @(posedge clk); #1; k++;
            cmd_start = (k == ign_at);
            if (k == ign_at) begin cmd_base = base ^ 12'h555; cmd_len = 7; end
            st_ready = ready_val(mode, k);
            if (done_cyc_q.size() > d0) fin = 1'b1;
        end
        check("cmd_finished", fin, 1);
        st_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        verify(base, len);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cs"}, sram_chipselect, 0);
        check({tag, "_addr"}, sram_address, 0);
        check({tag, "_valid"}, st_valid, 0);
        check({tag, "_data"}, st_data, 0);
        check({tag, "_last"}, st_last, 0);
        check({tag, "_write"}, sram_write, 0);
        check({tag, "_be"}, sram_byteenable, 2'b11);
        check({tag, "_clken"}, sram_clken, 1);
    endtask

    initial begin
        int k;
        reset_n = 1'b0; cmd_start = 1'b0; cmd_base = '0; cmd_len = '0; st_ready = 1'b1;
`ifdef SRAM_RD_STRIDE_EN
        cmd_stride = '0;
`endif
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'hA5A5;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic read with cycle-accurate latency checks.
        run_cmd(12'h010, 8, 0, -1);
        if (got_q.size() > g0) check("first_valid_cycle", pop_cyc_q[g0] - t0, 3);
        check("busy_cycles", busy_cyc_q.size() - b0, 10);
        if (busy_cyc_q.size() - b0 == 10) begin
            check("busy_first", busy_cyc_q[b0] - t0, 1);
            check("busy_last", busy_cyc_q[b0+9] - t0, 10);
        end
        if (done_cyc_q.size() > d0) check("done_cycle", done_cyc_q[d0] - t0, 11);

        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);

        run_cmd(12'hFFE, 4, 0, -1);
        run_cmd(AW'($urandom), 16, 1, -1);
        run_cmd(AW'($urandom), 0, 0, -1);
        run_cmd(12'h2A0, 5, 0, 2);
        for (int r = 0; r < 3; r++) run_cmd(AW'($urandom), $urandom_range(40, 1), $urandom_range(1), -1);
        run_cmd(12'h123, 4096, 0, -1);

        // Reset abort at the third delivered word of ten.
        snap();
        start_cmd(12'h200, 10, 0);
        k = 0;
        while (got_q.size() - g0 < 3 && k < 50) begin
            @(posedge clk); #1; k++;
            cmd_start = 1'b0;
        end
        check("abort_reached_word3", got_q.size() - g0, 3);
        #2 reset_n = 1'b0;
        #1 check_idle_outputs("abort");
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        check("abort_no_done", done_cyc_q.size() - d0, 0);
        run_cmd(12'h100, 2, 0, -1);

`ifdef SRAM_RD_STRIDE_EN
        model_stride = 12'h400;
        run_cmd(12'h000, 5, 0, -1);
        model_stride = 0;
        run_cmd(12'h3C5, 3, 1, -1);
        model_stride = 1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
